// File: rtl/vga_blank_arbiter.sv
`default_nettype none
// ============================================================================
// vga_blank_arbiter : VGA timing master with a round-robin frame-state
//                     update arbiter that only grants during vertical blanking
// Rev 1.0
// ============================================================================
module vga_blank_arbiter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count,
  input  logic [1:0] i_Req,
  input  logic [1:0] i_Done,
  output logic [1:0] o_Gnt,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_ARB    = 3'd2,
    S_GRANT  = 3'd3,
    S_CLOSED = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_served;
  logic       r_ptr;
  logic       r_gnt_idx;

  logic       w_col_wrap;
  logic       w_frame_wrap;
  logic       w_win_open;
  logic       w_guard;
  logic       w_in_win;
  logic [9:0] w_col_nxt;
  logic [9:0] w_row_nxt;
  logic [1:0] w_avail;

  // Look-ahead on the counts so state changes coincide with the counts shown.
  assign w_col_wrap   = (o_Col_Count == 10'(TOTAL_COLS - 1));
  assign w_frame_wrap = w_col_wrap && (o_Row_Count == 10'(TOTAL_ROWS - 1));
  assign w_win_open   = w_col_wrap && (o_Row_Count == 10'(ACTIVE_ROWS - 1));
  assign w_guard      = w_col_wrap && (o_Row_Count == 10'(TOTAL_ROWS - 2));
  assign w_col_nxt    = w_col_wrap ? 10'd0 : o_Col_Count + 10'd1;
  assign w_row_nxt    = !w_col_wrap  ? o_Row_Count :
                        w_frame_wrap ? 10'd0 : o_Row_Count + 10'd1;
  assign w_in_win     = (o_Row_Count >= 10'(ACTIVE_ROWS)) &&
                        (o_Row_Count <= 10'(TOTAL_ROWS - 2));
  assign w_avail      = i_Req & ~r_served;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || !i_Enable) begin
      r_state       <= S_IDLE;
      r_served      <= 2'b00;
      r_ptr         <= 1'b0;
      r_gnt_idx     <= 1'b0;
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Col_Count   <= 10'd0;
      o_Row_Count   <= 10'd0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= 8'd0;
      o_Gnt         <= 2'b00;
      o_Overrun     <= 1'b0;
    end else begin
      o_Frame_Start <= 1'b0;
      o_Overrun     <= 1'b0;
      if (r_state == S_IDLE) begin
        // First enabled edge shows (0,0) without a frame-start pulse.
        o_Col_Count <= 10'd0;
        o_Row_Count <= 10'd0;
        o_HSync     <= 1'b1;
        o_VSync     <= 1'b1;
        r_state     <= S_SCAN;
      end else begin
        o_Col_Count <= w_col_nxt;
        o_Row_Count <= w_row_nxt;
        o_HSync     <= (w_col_nxt < 10'(ACTIVE_COLS));
        o_VSync     <= (w_row_nxt < 10'(ACTIVE_ROWS));
        if (w_frame_wrap) begin
          o_Frame_Start <= 1'b1;
          o_Frame_Count <= o_Frame_Count + 8'd1;
          r_served      <= 2'b00;
        end
        case (r_state)
          S_SCAN: begin
            if (w_win_open) r_state <= S_ARB;
          end
          S_ARB: begin
            if (w_guard) begin
              r_state <= S_CLOSED;
            end else if (w_in_win && (w_avail != 2'b00)) begin
              r_state <= S_GRANT;
              if (w_avail == 2'b11) begin
                r_gnt_idx <= r_ptr;
                o_Gnt     <= r_ptr ? 2'b10 : 2'b01;
                r_ptr     <= ~r_ptr;
              end else if (w_avail[0]) begin
                r_gnt_idx <= 1'b0;
                o_Gnt     <= 2'b01;
              end else begin
                r_gnt_idx <= 1'b1;
                o_Gnt     <= 2'b10;
              end
            end
          end
          S_GRANT: begin
            // A release sampled on the guard edge wins over the forced revoke.
            if (i_Done[r_gnt_idx]) begin
              o_Gnt               <= 2'b00;
              r_served[r_gnt_idx] <= 1'b1;
              r_state             <= w_guard ? S_CLOSED : S_ARB;
            end else if (w_guard) begin
              o_Gnt               <= 2'b00;
              r_served[r_gnt_idx] <= 1'b1;
              o_Overrun           <= 1'b1;
              r_state             <= S_CLOSED;
            end
          end
          S_CLOSED: begin
            if (w_frame_wrap) r_state <= S_SCAN;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_blank_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_blank_arbiter : scenario tasks plus randomized run against a
//                        position-based reference model of timing and grants
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vga_blank_arbiter;

  localparam int TC = 10;
  localparam int TR = 8;
  localparam int AC = 6;
  localparam int AR = 5;
  localparam int FR = TC * TR;

  logic       clk = 1'b0;
  logic       i_Rst, i_Enable;
  logic [1:0] i_Req, i_Done;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Overrun;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic [7:0] o_Frame_Count;
  logic [1:0] o_Gnt;
  logic [33:0] w_obs;

  int checks = 0;
  int errors = 0;

  // Reference model: m_t is cycles since the first enabled edge (-1 = idle).
  int         m_t = -1;
  int         m_holder = -1;
  int         m_ptr = 0;
  logic [1:0] m_served = 2'b00;
  logic       m_ovr = 1'b0;

  always #5 clk = ~clk;

  vga_blank_arbiter #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Enable     (i_Enable),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Start(o_Frame_Start),
    .o_Frame_Count(o_Frame_Count),
    .i_Req        (i_Req),
    .i_Done       (i_Done),
    .o_Gnt        (o_Gnt),
    .o_Overrun    (o_Overrun)
  );

  assign w_obs = {o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frame_Start,
                  o_Frame_Count, o_Gnt, o_Overrun};

  task automatic model_edge(input logic rst, input logic en,
                            input logic [1:0] req, input logic [1:0] done);
    int pt, prow, p;
    logic guard;
    logic [1:0] avail;
    if (rst || !en) begin
      m_t = -1; m_holder = -1; m_ptr = 0; m_served = 2'b00; m_ovr = 1'b0;
      return;
    end
    pt    = m_t;
    m_t   = m_t + 1;
    m_ovr = 1'b0;
    p     = m_t % FR;
    prow  = (pt >= 0) ? (pt % FR) / TC : -1;
    guard = (p == (TR - 1) * TC);
    if (p == 0) m_served = 2'b00;
    if (m_holder >= 0) begin
      if (done[m_holder]) begin
        m_served[m_holder] = 1'b1; m_holder = -1;
      end else if (guard) begin
        m_served[m_holder] = 1'b1; m_holder = -1; m_ovr = 1'b1;
      end
    end else if (prow >= AR && prow <= TR - 2 && !guard) begin
      avail = req & ~m_served;
      if (avail == 2'b11) begin
        m_holder = m_ptr; m_ptr = 1 - m_ptr;
      end else if (avail[0]) m_holder = 0;
      else if (avail[1]) m_holder = 1;
    end
  endtask

  function automatic logic [33:0] exp_vec();
    int p, col, row;
    logic [1:0] g;
    if (m_t < 0) return 34'd0;
    p   = m_t % FR;
    col = p % TC;
    row = p / TC;
    g   = (m_holder < 0) ? 2'b00 : (m_holder == 0 ? 2'b01 : 2'b10);
    return {1'(col < AC), 1'(row < AR), 10'(col), 10'(row),
            1'(m_t > 0 && p == 0), 8'(m_t / FR), g, m_ovr};
  endfunction

  task automatic step(input logic rst, input logic en,
                      input logic [1:0] req, input logic [1:0] done);
    i_Rst = rst; i_Enable = en; i_Req = req; i_Done = done;
    @(posedge clk);
    model_edge(rst, en, req, done);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 2'b11, 2'b11);
    checks++;
    if (w_obs !== 34'd0) begin
      errors++; $display("FAIL reset got=%h exp=%h", w_obs, 34'd0);
    end
    step(1'b0, 1'b0, 2'b11, 2'b00);
    checks++;
    if (w_obs !== 34'd0) begin
      errors++; $display("FAIL idle_disabled got=%h exp=%h", w_obs, 34'd0);
    end
  endtask

  task automatic test_counters();
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c <= 2 * FR; c++) begin
      step(1'b0, 1'b1, 2'b00, 2'b00);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL counters t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
    end
    checks++;
    if (o_Frame_Count !== 8'd2 || o_Frame_Start !== 1'b1) begin
      errors++;
      $display("FAIL frame_count_160 got=%0d/%b exp=2/1", o_Frame_Count, o_Frame_Start);
    end
  endtask

  task automatic test_single_req();
    logic [1:0] d;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 2 * FR; c++) begin
      d = (c == 55 || c == 135) ? 2'b01 : 2'b00;
      step(1'b0, 1'b1, 2'b01, d);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL single_req t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
      if (c == 51 || c == 131 || c == 55 || c == 60) begin
        checks++;
        if (o_Gnt !== ((c == 51 || c == 131) ? 2'b01 : 2'b00)) begin
          errors++; $display("FAIL single_gnt t=%0d got=%b", c, o_Gnt);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 3 * FR; c++) begin
      step(1'b0, 1'b1, 2'b11, o_Gnt);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL round_robin t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
      if (c == 51 || c == 53 || c == 131 || c == 133 || c == 211) begin
        checks++;
        if (o_Gnt !== ((c == 51 || c == 133 || c == 211) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_order t=%0d got=%b", c, o_Gnt);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [1:0] d;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 2 * FR; c++) begin
      d = (c == 150) ? 2'b01 : 2'b00;
      step(1'b0, 1'b1, 2'b01, d);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL overrun t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
      if (c == 69 || c == 70 || c == 71 || c == 149 || c == 150) begin
        checks++;
        if ({o_Gnt, o_Overrun} !== ((c == 69 || c == 149) ? 3'b010 :
                                    (c == 70) ? 3'b001 : 3'b000)) begin
          errors++; $display("FAIL overrun_edge t=%0d got gnt=%b ovr=%b", c, o_Gnt, o_Overrun);
        end
      end
    end
  endtask

  task automatic test_done_other_and_disable();
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 1'b1, 2'b01, (c > 51) ? 2'b10 : 2'b00);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL done_other t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
    end
    checks++;
    if (o_Gnt !== 2'b01) begin
      errors++; $display("FAIL done_other_held got=%b exp=01", o_Gnt);
    end
    step(1'b0, 1'b0, 2'b01, 2'b00);
    checks++;
    if (w_obs !== 34'd0) begin
      errors++; $display("FAIL disable_mid got=%h exp=%h", w_obs, 34'd0);
    end
  endtask

  task automatic test_reset_mid_grant();
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c <= 143; c++) begin
      step(1'b0, 1'b1, 2'b01, (c == 55) ? 2'b01 : 2'b00);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL pre_reset t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
    end
    step(1'b1, 1'b1, 2'b01, 2'b00);
    checks++;
    if (w_obs !== 34'd0) begin
      errors++; $display("FAIL reset_mid_grant got=%h exp=%h", w_obs, 34'd0);
    end
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 2'b01, 2'b00);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL restart t=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
      if (c == 0) begin
        checks++;
        if ({o_Col_Count, o_Row_Count, o_Frame_Start} !== 21'd0) begin
          errors++;
          $display("FAIL restart_origin got=%0d,%0d fs=%b", o_Row_Count, o_Col_Count, o_Frame_Start);
        end
      end
    end
  endtask

  task automatic test_random();
    logic rst, en;
    logic [1:0] req, done;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 199) != 0);
      req  = 2'($urandom_range(0, 3));
      done = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(rst, en, req, done);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, w_obs, exp_vec());
      end
    end
  endtask

  initial begin
    i_Rst = 1'b1; i_Enable = 1'b0; i_Req = 2'b00; i_Done = 2'b00;
    test_reset();
    test_counters();
    test_single_req();
    test_round_robin();
    test_overrun();
    test_done_other_and_disable();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
